// File: rtl/seg_dynamic_ctrl.sv
// ---------------------------------------------------------------------------------------------
// seg_dynamic_ctrl
//
// Time-multiplexed scan controller for a 6-digit common-anode 7-segment display. One seg bus is
// shared by six digits, one digit per scan slot. The first BLANK_CYC cycles of each slot keep
// every digit off, so the previous digit's pattern never ghosts onto the next one.
//
// Upstream logic hands over six hex nibbles plus decimal points with a single-cycle load strobe.
// The data waits in a pending buffer and is moved into the display shadow only at a frame
// boundary (end of the digit 5 slot), so a frame never shows a mix of old and new digits.
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   defined     : digit k (k >= 1) shows all segments off (sel still asserted) when shadow
//                 nibbles k..5 and point bits k..5 are all zero. Digit 0 is never blanked.
//   not defined : all six digits are always decoded (leading zeros show as "0").
//
// Parameters:
//   CNT_MAX    scan-slot length minus 1, in sys_clk cycles
//   BLANK_CYC  all-off cycles at the start of each slot; must be < CNT_MAX
//
// Ports:
//   sys_clk     in   1   system clock
//   sys_rst     in   1   asynchronous reset, active-high
//   data_in     in   24  six hex nibbles; data_in[3:0] = digit 0 (sel[0], rightmost)
//   point_in    in   6   decimal point per digit, 1 = lit
//   en_in       in   1   display enable; 0 = dark, scanning and load path keep running
//   load        in   1   strobe: capture data_in/point_in into the pending buffer
//   load_ack    out  1   pulse: pending data moved into the display shadow
//   frame_done  out  1   pulse in the cycle after the digit 5 slot ends
//   sel         out  6   digit select, one-hot, active-high
//   seg         out  8   segments, active-low; seg[7] = decimal point
// ---------------------------------------------------------------------------------------------
module seg_dynamic_ctrl #(
  parameter logic [15:0] CNT_MAX   = 16'd49_999,
  parameter logic [15:0] BLANK_CYC = 16'd500
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [23:0] data_in,
  input  logic [5:0]  point_in,
  input  logic        en_in,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_done,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam logic [2:0] LastDigit = 3'd5;

  // Scan state
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        tick;
  logic        boundary;

  // Data path: pending buffer and display shadow
  logic [23:0] pend_data_q, pend_data_d;
  logic [5:0]  pend_point_q, pend_point_d;
  logic        pend_valid_q, pend_valid_d;
  logic [23:0] shadow_data_q, shadow_data_d;
  logic [5:0]  shadow_point_q, shadow_point_d;

  // Registered outputs
  logic        load_ack_q, load_ack_d;
  logic        frame_done_q, frame_done_d;
  logic [5:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;

  // Current digit decode helpers
  logic [23:0] nib_sh;
  logic [3:0]  cur_nib;
  logic [5:0]  point_sh;
  logic        cur_dp;
  logic        lead_blank;

  // Hex font, active-low, segments g..a in bits 6..0.
  function automatic logic [6:0] font7(input logic [3:0] nib);
    logic [6:0] pat;
    pat = 7'h7F;
    unique case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // ---------------------------------------------------------------------------
  // Slot counter and digit index
  // ---------------------------------------------------------------------------
  assign tick     = (cnt_q == CNT_MAX);
  assign boundary = tick && (idx_q == LastDigit);

  always_comb begin
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LastDigit) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Load handshake: pending buffer -> shadow at frame boundary
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_data_d    = pend_data_q;
    pend_point_d   = pend_point_q;
    pend_valid_d   = pend_valid_q;
    shadow_data_d  = shadow_data_q;
    shadow_point_d = shadow_point_q;
    load_ack_d     = 1'b0;
    frame_done_d   = boundary;

    if (boundary) begin
      if (load) begin
        // A strobe landing on the boundary bypasses the pending buffer; it is newer than
        // anything already pending.
        shadow_data_d  = data_in;
        shadow_point_d = point_in;
        pend_valid_d   = 1'b0;
        load_ack_d     = 1'b1;
      end else if (pend_valid_q) begin
        shadow_data_d  = pend_data_q;
        shadow_point_d = pend_point_q;
        pend_valid_d   = 1'b0;
        load_ack_d     = 1'b1;
      end
    end else if (load) begin
      // Last write before the boundary wins; only one ack follows.
      pend_data_d  = data_in;
      pend_point_d = point_in;
      pend_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode
  // ---------------------------------------------------------------------------
  always_comb begin
    nib_sh   = shadow_data_q >> {idx_q, 2'b00};
    cur_nib  = nib_sh[3:0];
    point_sh = shadow_point_q >> idx_q;
    cur_dp   = point_sh[0];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[k] = nibbles k..5 and points k..5 are all zero.
  logic [5:0] zero_from;
  logic [5:0] zero_sh;

  always_comb begin
    zero_from    = '0;
    zero_from[5] = (shadow_data_q[23:20] == 4'h0) && !shadow_point_q[5];
    for (int k = 4; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (shadow_data_q[k*4 +: 4] == 4'h0) && !shadow_point_q[k];
    end
    zero_sh    = zero_from >> idx_q;
    lead_blank = (idx_q != 3'd0) && zero_sh[0];
  end
`else
  assign lead_blank = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output stage: one cycle after the counter/index state it reflects
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d = 6'b000000;
    seg_d = 8'hFF;
    if ((cnt_q >= BLANK_CYC) && en_in) begin
      sel_d = 6'b000001 << idx_q;
      if (!lead_blank) begin
        seg_d = {!cur_dp, font7(cur_nib)};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      pend_data_q    <= '0;
      pend_point_q   <= '0;
      pend_valid_q   <= 1'b0;
      shadow_data_q  <= '0;
      shadow_point_q <= '0;
      load_ack_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      sel_q          <= 6'b000000;
      seg_q          <= 8'hFF;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      pend_data_q    <= pend_data_d;
      pend_point_q   <= pend_point_d;
      pend_valid_q   <= pend_valid_d;
      shadow_data_q  <= shadow_data_d;
      shadow_point_q <= shadow_point_d;
      load_ack_q     <= load_ack_d;
      frame_done_q   <= frame_done_d;
      sel_q          <= sel_d;
      seg_q          <= seg_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;
  assign sel        = sel_q;
  assign seg        = seg_q;

endmodule
